// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one alu between two valid/ready requesters,
// round-robin granted and executed one operation at a time.
module alu #(
   parameter int SIZE = 8
) (
   input  logic              en_i,
   input  logic [3:0]        cmd_i,
   input  logic [SIZE-1:0]   a_i,
   input  logic [SIZE-1:0]   b_i,
   output logic [2*SIZE-1:0] result_o,
   output logic              overflow_o
);
   logic [SIZE:0]   add_u, sub_u;
   logic [SIZE-1:0] sum, diff;
   logic            add_s_ovf, sub_s_ovf;
   assign add_u = {1'b0, a_i} + {1'b0, b_i};
   assign sub_u = {1'b0, a_i} - {1'b0, b_i};
   assign sum = add_u[SIZE-1:0];
   assign diff = sub_u[SIZE-1:0];
   assign add_s_ovf = (a_i[SIZE-1] == b_i[SIZE-1]) & (sum[SIZE-1] != a_i[SIZE-1]);
   assign sub_s_ovf = (a_i[SIZE-1] != b_i[SIZE-1]) & (diff[SIZE-1] != a_i[SIZE-1]);
   // unsigned results are zero-extended, signed results sign-extended
   always_comb begin
      result_o = '0;
      overflow_o = 1'b0;
      if (en_i)
         case (cmd_i)
            4'd0: result_o = {{SIZE{1'b0}}, a_i & b_i};
            4'd1: result_o = {{SIZE{1'b0}}, a_i | b_i};
            4'd2: result_o = {{SIZE{1'b0}}, a_i ^ b_i};
            4'd3: result_o = {{SIZE{1'b0}}, ~a_i};
            4'd4: begin result_o = {{SIZE{1'b0}}, sum}; overflow_o = add_u[SIZE]; end
            4'd5: begin result_o = {{SIZE{sum[SIZE-1]}}, sum}; overflow_o = add_s_ovf; end
            4'd6: begin result_o = {{SIZE{1'b0}}, diff}; overflow_o = sub_u[SIZE]; end
            4'd7: begin result_o = {{SIZE{diff[SIZE-1]}}, diff}; overflow_o = sub_s_ovf; end
            4'd8: result_o = {{SIZE{1'b0}}, a_i} * {{SIZE{1'b0}}, b_i};
            default: ;
         endcase
   end
endmodule

module alu_scheduler #(
   parameter int SIZE = 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic [3:0]        req0_command_i,
   input  logic [SIZE-1:0]   req0_a_i,
   input  logic [SIZE-1:0]   req0_b_i,
   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic [3:0]        req1_command_i,
   input  logic [SIZE-1:0]   req1_a_i,
   input  logic [SIZE-1:0]   req1_b_i,
   output logic              rsp0_valid_o,
   input  logic              rsp0_ready_i,
   output logic              rsp1_valid_o,
   input  logic              rsp1_ready_i,
   output logic [2*SIZE-1:0] rsp_result_o,
   output logic              rsp_overflow_o,
   output logic              rsp_error_o,
   output logic              busy_o
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d, gnt_q, gnt_d;
   logic [3:0]        cmd_q, cmd_d;
   logic [SIZE-1:0]   a_q, a_d, b_q, b_d;
   logic [2*SIZE-1:0] res_q, res_d, alu_res;
   logic              ovf_q, ovf_d, err_q, err_d, alu_ovf;
   logic              grant0, grant1, req_hs, rsp_hs;
   alu #(.SIZE(SIZE)) u_alu (
      .en_i       (state_q == EXEC),
      .cmd_i      (cmd_q),
      .a_i        (a_q),
      .b_i        (b_q),
      .result_o   (alu_res),
      .overflow_o (alu_ovf)
   );
   // on a tie the requester that did not win last time is granted
   assign grant0 = req0_valid_i & (~req1_valid_i | last_grant_q);
   assign grant1 = req1_valid_i & ~grant0;
   assign req0_ready_o = rst_n_i & (state_q == IDLE) & grant0;
   assign req1_ready_o = rst_n_i & (state_q == IDLE) & grant1;
   assign req_hs = req0_ready_o | req1_ready_o;
   assign rsp0_valid_o = (state_q == RESP) & ~gnt_q;
   assign rsp1_valid_o = (state_q == RESP) & gnt_q;
   assign rsp_hs = (rsp0_valid_o & rsp0_ready_i) | (rsp1_valid_o & rsp1_ready_i);
   assign rsp_result_o = res_q;
   assign rsp_overflow_o = ovf_q;
   assign rsp_error_o = err_q;
   assign busy_o = state_q != IDLE;
   always_comb begin
      state_d = state_q;
      last_grant_d = last_grant_q;
      gnt_d = gnt_q;
      cmd_d = cmd_q;
      a_d = a_q;
      b_d = b_q;
      res_d = res_q;
      ovf_d = ovf_q;
      err_d = err_q;
      case (state_q)
         IDLE: if (req_hs) begin
            state_d = EXEC;
            gnt_d = req1_ready_o;
            cmd_d = req1_ready_o ? req1_command_i : req0_command_i;
            a_d = req1_ready_o ? req1_a_i : req0_a_i;
            b_d = req1_ready_o ? req1_b_i : req0_b_i;
         end
         EXEC: begin
            state_d = RESP;
            err_d = cmd_q > 4'd8;
            res_d = (cmd_q > 4'd8) ? '0 : alu_res;
            ovf_d = (cmd_q <= 4'd8) & alu_ovf;
         end
         RESP: if (rsp_hs) begin
            state_d = IDLE;
            last_grant_d = gnt_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         last_grant_q <= 1'b1;
         gnt_q <= 1'b0;
         cmd_q <= '0;
         a_q <= '0;
         b_q <= '0;
         res_q <= '0;
         ovf_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_grant_q <= last_grant_d;
         gnt_q <= gnt_d;
         cmd_q <= cmd_d;
         a_q <= a_d;
         b_q <= b_d;
         res_q <= res_d;
         ovf_q <= ovf_d;
         err_q <= err_d;
      end
   end
endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: directed vector table plus hand sequences for alu_scheduler.
module tb_alu_scheduler;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [3:0]  req0_command = '0, req1_command = '0;
   logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [15:0] rsp_result;
   logic        rsp_overflow, rsp_error, busy;
   int          total = 0, bad = 0;

   typedef struct {
      logic        p;
      logic [3:0]  cmd;
      logic [7:0]  a, b;
      logic [15:0] res;
      logic        ovf, err;
   } vec_t;
   vec_t vecs[13];

   alu_scheduler #(.SIZE(8)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_command_i(req0_command),
      .req0_a_i(req0_a), .req0_b_i(req0_b),
      .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_command_i(req1_command),
      .req1_a_i(req1_a), .req1_b_i(req1_b),
      .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready),
      .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready),
      .rsp_result_o(rsp_result), .rsp_overflow_o(rsp_overflow), .rsp_error_o(rsp_error),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_op(input vec_t v);
      if (v.p) begin
         req1_valid = 1'b1; req1_command = v.cmd; req1_a = v.a; req1_b = v.b; rsp1_ready = 1'b1;
      end else begin
         req0_valid = 1'b1; req0_command = v.cmd; req0_a = v.a; req0_b = v.b; rsp0_ready = 1'b1;
      end
      #1;
      chk("hs_ready", {req1_ready, req0_ready}, v.p ? 2'b10 : 2'b01);
      chk("hs_busy", busy, 1'b0);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("exec_busy", busy, 1'b1);
      chk("exec_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
      step();
      chk("resp_valid", {rsp1_valid, rsp0_valid}, v.p ? 2'b10 : 2'b01);
      chk("resp_result", rsp_result, v.res);
      chk("resp_flags", {rsp_overflow, rsp_error}, {v.ovf, v.err});
      chk("resp_busy", busy, 1'b1);
      step();
      chk("idle_busy", busy, 1'b0);
      chk("idle_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
   endtask

   initial begin
      int cyc;
      logic g;
      vecs[0]  = '{1'b0, 4'd8,  8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 4'd4,  8'hC8, 8'h64, 16'h002C, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 4'd0,  8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 4'd1,  8'hF0, 8'h0F, 16'h00FF, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 4'd2,  8'hFF, 8'h0F, 16'h00F0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 4'd3,  8'h0F, 8'h00, 16'h00F0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 4'd5,  8'h7F, 8'h01, 16'hFF80, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 4'd6,  8'h05, 8'h0A, 16'h00FB, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 4'd7,  8'h80, 8'h01, 16'h007F, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 4'd12, 8'hAA, 8'h55, 16'h0000, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 4'd9,  8'hFF, 8'hFF, 16'h0000, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 4'd6,  8'h0A, 8'h05, 16'h0005, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 4'd5,  8'hFF, 8'hFF, 16'hFFFE, 1'b0, 1'b0};

      req0_valid = 1'b1;
      req1_valid = 1'b1;
      step();
      step();
      chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp", {rsp1_valid, rsp0_valid, rsp_overflow, rsp_error}, 4'b0000);
      chk("rst_result", rsp_result, 16'h0000);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 13; i++) do_op(vecs[i]);

      // round robin from reset: both requesters held valid
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_command = 4'd0; req0_a = 8'h0F; req0_b = 8'hFF; rsp0_ready = 1'b1;
      req1_valid = 1'b1; req1_command = 4'd1; req1_a = 8'hF0; req1_b = 8'h00; rsp1_ready = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         cyc = 0;
         while (!(req0_ready | req1_ready) && cyc < 10) begin
            step();
            cyc++;
         end
         chk("rr_granted", req0_ready | req1_ready, 1'b1);
         chk("rr_exclusive", req0_ready & req1_ready, 1'b0);
         g = req1_ready;
         chk("rr_order", g, k[0]);
         step();
         step();
         chk("rr_rsp", {rsp1_valid, rsp0_valid}, g ? 2'b10 : 2'b01);
         chk("rr_result", rsp_result, g ? 16'h00F0 : 16'h000F);
         step();
      end

      // backpressure on req0 while req1 waits; rsp1_ready high must be ignored
      req0_command = 4'd0; req0_a = 8'hF0; req0_b = 8'h3C; rsp0_ready = 1'b0;
      req1_command = 4'd4; req1_a = 8'h01; req1_b = 8'h02;
      #1;
      chk("bp_grant", {req1_ready, req0_ready}, 2'b01);
      step();
      req0_valid = 1'b0;
      step();
      for (int c = 0; c < 5; c++) begin
         chk("bp_rsp", {rsp1_valid, rsp0_valid}, 2'b01);
         chk("bp_result", rsp_result, 16'h0030);
         chk("bp_req1_ready", req1_ready, 1'b0);
         step();
      end
      rsp0_ready = 1'b1;
      step();
      chk("bp_req1_grant", {req1_ready, req0_ready}, 2'b10);
      step();
      req1_valid = 1'b0;
      step();
      chk("bp_req1_rsp", {rsp1_valid, rsp0_valid}, 2'b10);
      chk("bp_req1_result", rsp_result, 16'h0003);
      step();

      // reset during EXEC of a req1 op drops it
      req1_valid = 1'b1; req1_command = 4'd4; req1_a = 8'h10; req1_b = 8'h20;
      #1;
      chk("mid_hs", req1_ready, 1'b1);
      step();
      req1_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_exec_busy", busy, 1'b1);
      step();
      chk("mid_idle", busy, 1'b0);
      chk("mid_no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_command = 4'd1; req0_a = 8'h01; req0_b = 8'h02;
      req1_valid = 1'b1;
      #1;
      chk("mid_first_grant", {req1_ready, req0_ready}, 2'b01);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("mid_exec_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
      step();
      chk("mid_rsp", {rsp1_valid, rsp0_valid}, 2'b01);
      chk("mid_result", rsp_result, 16'h0003);
      step();
      step();
      chk("mid_quiet", {rsp1_valid, rsp0_valid, busy}, 3'b000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
